addr_reg_stk: RTL and testbench

Parametrised address register for the simple processor datapath. It replaces the fixed 16-bit load/increment/reserved-load address register and adds a decrement path, a configurable step, and a hardware return-address stack. A reserved-vector load saves the current address, and a return command restores it. All state changes happen synchronously on `clk`; reset is asynchronous.

---
 rtl/addr_reg_stk.sv | 131 +++++++++++++
 tb/tb_addr_reg_stk.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/addr_reg_stk.sv
// Address register with load/inc/dec, reserved-vector call and a LIFO return stack.
// Optional `AR_WRAP_LIMIT_EN` folds inc/dec into the range 0..WRAP_LIMIT.
module addr_reg_stk #(
  parameter int unsigned P          = 15,
  parameter logic [P:0]  RSV_ADDR   = 16'h0FFE,
  parameter int unsigned STEP       = 1,
  parameter int unsigned STK_DEPTH  = 4,
  parameter logic [P:0]  WRAP_LIMIT = 16'h0FFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [P:0] data_in,
  input  logic       ld,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld_reserved,
  input  logic       ret,
  input  logic       clr_err,
  output logic [P:0] data_out,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_ovf,
  output logic       stk_unf
);

  localparam int unsigned SPW  = $clog2(STK_DEPTH + 1);
  localparam int unsigned IDXW = $clog2(STK_DEPTH);
  localparam logic [SPW-1:0] DEPTH_C = SPW'(STK_DEPTH);
  localparam logic [P:0]     STEP_P  = (P+1)'(STEP);

  logic [P:0]      r_addr;
  logic [SPW-1:0]  r_sp;
  logic            r_ovf;
  logic            r_unf;
  logic [P:0]      r_stk [STK_DEPTH];

  logic [P:0]      w_inc_addr;
  logic [P:0]      w_dec_addr;
  logic [P:0]      w_nxt_addr;
  logic [SPW-1:0]  w_sp_m1;
  logic [IDXW-1:0] w_wr_idx;
  logic [IDXW-1:0] w_rd_idx;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_set_ovf;
  logic            w_set_unf;

`ifdef AR_WRAP_LIMIT_EN
  // One extra bit keeps the sum exact before folding back into 0..WRAP_LIMIT.
  localparam logic [P+1:0] STEP_X = (P+2)'(STEP);
  localparam logic [P+1:0] LIM_X  = {1'b0, WRAP_LIMIT};
  localparam logic [P+1:0] LIM_P1 = LIM_X + 1'b1;
  logic [P+1:0] w_sum;

  always_comb begin
    w_sum      = {1'b0, r_addr} + STEP_X;
    w_inc_addr = (w_sum > LIM_X) ? (P+1)'(w_sum - LIM_P1) : w_sum[P:0];
    w_dec_addr = (r_addr < STEP_P) ? (P+1)'({1'b0, r_addr} + LIM_P1 - STEP_X)
                                   : r_addr - STEP_P;
  end
`else
  always_comb begin
    w_inc_addr = r_addr + STEP_P;
    w_dec_addr = r_addr - STEP_P;
  end
`endif

  assign w_empty  = (r_sp == '0);
  assign w_full   = (r_sp == DEPTH_C);
  assign w_sp_m1  = r_sp - 1'b1;
  assign w_wr_idx = r_sp[IDXW-1:0];
  assign w_rd_idx = w_sp_m1[IDXW-1:0];

  always_comb begin
    w_nxt_addr = r_addr;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    if (ld) begin
      w_nxt_addr = data_in;
    end else if (inc) begin
      w_nxt_addr = w_inc_addr;
    end else if (dec) begin
      w_nxt_addr = w_dec_addr;
    end else if (ld_reserved) begin
      // The vector load happens even when the push is dropped.
      w_nxt_addr = RSV_ADDR;
      if (w_full) w_set_ovf = 1'b1;
      else        w_push    = 1'b1;
    end else if (ret) begin
      if (w_empty) begin
        w_set_unf = 1'b1;
      end else begin
        w_pop      = 1'b1;
        w_nxt_addr = r_stk[w_rd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_sp   <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_addr <= w_nxt_addr;
      if (w_push)     r_sp <= r_sp + 1'b1;
      else if (w_pop) r_sp <= w_sp_m1;
      if (w_set_ovf)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_set_unf)    r_unf <= 1'b1;
      else if (clr_err) r_unf <= 1'b0;
    end
  end

  // Stack storage needs no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_stk[w_wr_idx] <= r_addr;
  end

  assign data_out  = r_addr;
  assign stk_empty = w_empty;
  assign stk_full  = w_full;
  assign stk_ovf   = r_ovf;
  assign stk_unf   = r_unf;

endmodule

// File: tb/tb_addr_reg_stk.sv
// Scoreboard bench for addr_reg_stk: directed commands push expected state,
// a monitor compares after each clock edge (or on demand for async reset).
module tb_addr_reg_stk;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        ld, inc, dec, ld_reserved, ret, clr_err;
  logic [15:0] data_out;
  logic        stk_empty, stk_full, stk_ovf, stk_unf;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [3:0]  flg;   // {empty, full, ovf, unf}
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  event chk_ev;

  addr_reg_stk #(
    .P(15), .RSV_ADDR(16'h0FFE), .STEP(1), .STK_DEPTH(4), .WRAP_LIMIT(16'h0FFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
    .ld_reserved(ld_reserved), .ret(ret), .clr_err(clr_err), .data_out(data_out),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares one queued expectation per clock edge or per explicit trigger.
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [3:0] got;
        e   = exp_q.pop_front();
        got = {stk_empty, stk_full, stk_ovf, stk_unf};
        n_total++;
        if (data_out === e.addr && got === e.flg) n_pass++;
        else $display("FAIL %s: got addr=%h e/f/o/u=%b, required addr=%h e/f/o/u=%b",
                      e.name, data_out, got, e.addr, e.flg);
      end
    end
  end

  task automatic push_exp(input string nm, input logic [15:0] a, input logic [3:0] f);
    exp_t e;
    e.name = nm; e.addr = a; e.flg = f;
    exp_q.push_back(e);
  endtask

  // cmd = {ld, inc, dec, ld_reserved, ret, clr_err}
  task automatic step(input string nm, input logic [5:0] cmd, input logic [15:0] din,
                      input logic [15:0] ea, input logic [3:0] ef);
    @(negedge clk);
    {ld, inc, dec, ld_reserved, ret, clr_err} = cmd;
    data_in = din;
    push_exp(nm, ea, ef);
  endtask

  localparam logic [5:0] C_LD  = 6'b100000;
  localparam logic [5:0] C_INC = 6'b010000;
  localparam logic [5:0] C_DEC = 6'b001000;
  localparam logic [5:0] C_RSV = 6'b000100;
  localparam logic [5:0] C_RET = 6'b000010;
  localparam logic [5:0] C_CLR = 6'b000001;

  initial begin
    rst_n = 1'b0;
    {ld, inc, dec, ld_reserved, ret, clr_err} = '0;
    data_in = '0;
    #2;
    push_exp("reset_state", 16'h0000, 4'b1000);
    ->chk_ev;
    @(negedge clk);
    rst_n = 1'b1;

    // load and increment
    step("ld_1234",  C_LD,  16'h1234, 16'h1234, 4'b1000);
    step("inc_1",    C_INC, 16'h0000, 16'h1235, 4'b1000);
    step("inc_2",    C_INC, 16'h0000, 16'h1236, 4'b1000);

    // call / load / return
    step("ld_0010",  C_LD,  16'h0010, 16'h0010, 4'b1000);
    step("call",     C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_0200",  C_LD,  16'h0200, 16'h0200, 4'b0000);
    step("ret",      C_RET, 16'h0000, 16'h0010, 4'b1000);

    // fill, overflow, drain, underflow
    step("ld_a1",    C_LD,  16'h0001, 16'h0001, 4'b1000);
    step("push1",    C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_a2",    C_LD,  16'h0002, 16'h0002, 4'b0000);
    step("push2",    C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_a3",    C_LD,  16'h0003, 16'h0003, 4'b0000);
    step("push3",    C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_a4",    C_LD,  16'h0004, 16'h0004, 4'b0000);
    step("push4",    C_RSV, 16'h0000, 16'h0FFE, 4'b0100);
    step("ld_a5",    C_LD,  16'h0005, 16'h0005, 4'b0100);
    step("push5_ov", C_RSV, 16'h0000, 16'h0FFE, 4'b0110);
    step("pop4",     C_RET, 16'h0000, 16'h0004, 4'b0010);
    step("pop3",     C_RET, 16'h0000, 16'h0003, 4'b0010);
    step("pop2",     C_RET, 16'h0000, 16'h0002, 4'b0010);
    step("pop1",     C_RET, 16'h0000, 16'h0001, 4'b1010);
    step("pop_unf",  C_RET, 16'h0000, 16'h0001, 4'b1011);
    step("clr_err",  C_CLR, 16'h0000, 16'h0001, 4'b1000);

    // priority: ld beats ld_reserved and ret, no stack side effect
    step("ld_0100",  C_LD,  16'h0100, 16'h0100, 4'b1000);
    step("call_b",   C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("prio_ld",  C_LD | C_RSV | C_RET, 16'hAAAA, 16'hAAAA, 4'b0000);
    step("prio_inc", C_INC | C_DEC | C_RET, 16'h0000, 16'hAAAB, 4'b0000);
    step("prio_dec", C_DEC | C_RSV, 16'h0000, 16'hAAAA, 4'b0000);
    step("ret_b",    C_RET, 16'h0000, 16'h0100, 4'b1000);

    // overflow in the same cycle as clr_err: set wins
    step("ld_11",    C_LD,  16'h0011, 16'h0011, 4'b1000);
    step("f1",       C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_12",    C_LD,  16'h0012, 16'h0012, 4'b0000);
    step("f2",       C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_13",    C_LD,  16'h0013, 16'h0013, 4'b0000);
    step("f3",       C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_14",    C_LD,  16'h0014, 16'h0014, 4'b0000);
    step("f4",       C_RSV, 16'h0000, 16'h0FFE, 4'b0100);
    step("ovf_clr",  C_RSV | C_CLR, 16'h0000, 16'h0FFE, 4'b0110);
    step("clr_ovf",  C_CLR, 16'h0000, 16'h0FFE, 4'b0100);
    step("ret_14",   C_RET, 16'h0000, 16'h0014, 4'b0000);

    // natural wrap
    step("ld_ffff",  C_LD,  16'hFFFF, 16'hFFFF, 4'b0000);
    step("inc_wrap", C_INC, 16'h0000, 16'h0000, 4'b0000);
    step("dec_wrap", C_DEC, 16'h0000, 16'hFFFF, 4'b0000);

    // async reset mid-sequence after three pushes
    step("ld_21",    C_LD,  16'h0021, 16'h0021, 4'b0000);
    step("ld_21b",   C_LD,  16'h0021, 16'h0021, 4'b0000);
    @(negedge clk);
    {ld, inc, dec, ld_reserved, ret, clr_err} = '0;
    #2;
    rst_n = 1'b0;
    push_exp("async_reset", 16'h0000, 4'b1000);
    ->chk_ev;
    @(negedge clk);
    rst_n = 1'b1;
    step("ld_31",    C_LD,  16'h0031, 16'h0031, 4'b1000);
    step("s1",       C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("ld_32",    C_LD,  16'h0032, 16'h0032, 4'b0000);
    step("s2",       C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    step("s3",       C_RSV, 16'h0000, 16'h0FFE, 4'b0000);
    @(negedge clk);
    {ld, inc, dec, ld_reserved, ret, clr_err} = '0;
    #2;
    rst_n = 1'b0;
    push_exp("reset_3push", 16'h0000, 4'b1000);
    ->chk_ev;
    @(negedge clk);
    rst_n = 1'b1;
    step("ret_after_rst", C_RET, 16'h0000, 16'h0000, 4'b1001);

    @(negedge clk);
    {ld, inc, dec, ld_reserved, ret, clr_err} = '0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
